// File: rtl/sample_event_monitor.sv
// sample_event_monitor
// Watches the a/b register stage outputs, detects and counts toggles on the
// a and b channels, and checks that a_inv1/a_inv2 stay complementary.
// Every cycle carrying an edge, or the entry into a fault, is queued as one
// record into a small FIFO that is drained through a valid/ready handshake.
// Optional feature macro: SAMPLE_EVT_TIMESTAMP_EN prepends a free-running
// TS_W-bit cycle stamp to each record.
module sample_event_monitor #(
`ifdef SAMPLE_EVT_TIMESTAMP_EN
  parameter int TS_W       = 16,
`endif
  parameter int CNT_W      = 8,
  parameter int ERR_HOLD   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_inv1,
  input  logic a_inv2,
  input  logic b_inv1,
  input  logic clr,
  input  logic evt_ready,
  output logic evt_valid,
`ifdef SAMPLE_EVT_TIMESTAMP_EN
  output logic [TS_W+2*CNT_W+2:0] evt_data,
`else
  output logic [2*CNT_W+2:0] evt_data,
`endif
  output logic fault,
  output logic overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] HOLD_MAX = 4'(ERR_HOLD);
`ifdef SAMPLE_EVT_TIMESTAMP_EN
  localparam int DW = TS_W + 2*CNT_W + 3;
`else
  localparam int DW = 2*CNT_W + 3;
`endif

  typedef enum logic [1:0] {
    ST_OK,
    ST_SUSPECT,
    ST_FAULT
  } state_t;

  logic a_s, a2_s, b_s, s_valid;
  logic a, b, a_prev, b_prev, primed;
  logic a_edge_r, b_edge_r, fault_on_r;
  logic mismatch, enter_fault;
  state_t state, next_state;
  logic [3:0] hold_cnt, next_hold;
  logic [CNT_W-1:0] a_cnt, b_cnt, a_cnt_next, b_cnt_next;
  logic push, pop, full, empty, accept;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [DW-1:0] record;

  assign a        = a2_s;
  assign b        = ~b_s;
  assign mismatch = (a_s == a2_s);

  // Stage 1: capture the register-stage outputs; reset to a complementary
  // idle pattern so the reset values themselves never look like a mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s     <= 1'b1;
      a2_s    <= 1'b0;
      b_s     <= 1'b1;
      s_valid <= 1'b0;
    end else begin
      a_s     <= a_inv1;
      a2_s    <= a_inv2;
      b_s     <= b_inv1;
      s_valid <= 1'b1;
    end
  end

  // Edge detection: the first real sample only seeds the prev registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed   <= 1'b0;
      a_prev   <= 1'b0;
      b_prev   <= 1'b0;
      a_edge_r <= 1'b0;
      b_edge_r <= 1'b0;
    end else begin
      primed   <= s_valid;
      a_prev   <= a;
      b_prev   <= b;
      a_edge_r <= primed & (a != a_prev);
      b_edge_r <= primed & (b != b_prev);
    end
  end

  // Fault FSM state register; fault_on pulses for the entry cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_OK;
      hold_cnt   <= 4'd0;
      fault      <= 1'b0;
      fault_on_r <= 1'b0;
    end else begin
      state      <= next_state;
      hold_cnt   <= next_hold;
      fault      <= (next_state == ST_FAULT);
      fault_on_r <= enter_fault;
    end
  end

  // Fault FSM next state: a mismatch must persist ERR_HOLD cycles to fault.
  always_comb begin
    next_state  = state;
    next_hold   = hold_cnt;
    enter_fault = 1'b0;
    case (state)
      ST_OK: begin
        if (mismatch) begin
          if (HOLD_MAX == 4'd1) begin
            next_state  = ST_FAULT;
            enter_fault = 1'b1;
          end else begin
            next_state = ST_SUSPECT;
            next_hold  = 4'd1;
          end
        end
      end
      ST_SUSPECT: begin
        if (mismatch) begin
          next_hold = hold_cnt + 4'd1;
          if (hold_cnt + 4'd1 == HOLD_MAX) begin
            next_state  = ST_FAULT;
            enter_fault = 1'b1;
          end
        end else begin
          next_state = ST_OK;
          next_hold  = 4'd0;
        end
      end
      ST_FAULT: begin
        if (clr && !mismatch) begin
          next_state = ST_OK;
          next_hold  = 4'd0;
        end
      end
      default: begin
        next_state = ST_OK;
        next_hold  = 4'd0;
      end
    endcase
  end

  assign a_cnt_next = a_cnt + CNT_W'(a_edge_r);
  assign b_cnt_next = b_cnt + CNT_W'(b_edge_r);

  // Toggle counters advance on every edge, even when the record is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      a_cnt <= a_cnt_next;
      b_cnt <= b_cnt_next;
    end
  end

`ifdef SAMPLE_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running cycle stamp, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 1'b1;
  end

  assign record = {ts_cnt, a_edge_r, b_edge_r, fault_on_r, a_cnt_next, b_cnt_next};
`else
  assign record = {a_edge_r, b_edge_r, fault_on_r, a_cnt_next, b_cnt_next};
`endif

  assign push      = a_edge_r | b_edge_r | fault_on_r;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign evt_valid = ~empty;
  assign pop       = evt_valid & evt_ready;
  assign accept    = push & (~full | pop);
  assign evt_data  = evt_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // FIFO pointers and sticky overflow; a new drop wins over a same-cycle clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      overflow <= (push & full & ~pop) | (overflow & ~clr);
    end
  end

  // FIFO storage; contents are never visible while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= record;
  end

endmodule

// File: tb/tb_sample_event_monitor.sv
// tb_sample_event_monitor
// Directed test of sample_event_monitor with default parameters
// (CNT_W=8, ERR_HOLD=2, FIFO_DEPTH=4). Inputs change 1 time unit after a
// rising edge and outputs are checked at that same point.
module tb_sample_event_monitor;

`ifdef SAMPLE_EVT_TIMESTAMP_EN
  localparam int DW = 16 + 19;
`else
  localparam int DW = 19;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_inv1 = 1'b1;
  logic a_inv2 = 1'b0;
  logic b_inv1 = 1'b1;
  logic clr = 1'b0;
  logic evt_ready = 1'b0;
  logic evt_valid, fault, overflow;
  logic [DW-1:0] evt_data;
  logic a_val = 1'b0;
  logic b_val = 1'b0;
  int checks = 0;
  int errors = 0;

  sample_event_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .a_inv1    (a_inv1),
    .a_inv2    (a_inv2),
    .b_inv1    (b_inv1),
    .clr       (clr),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .fault     (fault),
    .overflow  (overflow)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic logic [18:0] rec(input logic ae, input logic be, input logic fo,
                                      input logic [7:0] ac, input logic [7:0] bc);
    return {ae, be, fo, ac, bc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic a, input logic b);
    a_val  = a;
    b_val  = b;
    a_inv1 = ~a;
    a_inv2 = a;
    b_inv1 = ~b;
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [18:0] observed, input logic [18:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %05h expected %05h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    step();
  endtask

  // Toggle the selected channels once and follow the record through the
  // two-edge latency and its pop (evt_ready must be high).
  task automatic doEvent(input logic ta, input logic tb_, input logic [18:0] exp, input string tag);
    applyStimulus(a_val ^ ta, b_val ^ tb_);
    step();
    step();
    checkBit({tag, "_latency"}, evt_valid, 1'b0);
    step();
    checkBit({tag, "_valid"}, evt_valid, 1'b1);
    checkOutput({tag, "_data"}, evt_data[18:0], exp);
    step();
    checkBit({tag, "_popped"}, evt_valid, 1'b0);
  endtask

  // Directed sequence
  initial begin
    step();
    step();
    checkBit("rst_valid", evt_valid, 1'b0);
    checkOutput("rst_data", evt_data[18:0], 19'h0);
    checkBit("rst_fault", fault, 1'b0);
    checkBit("rst_overflow", overflow, 1'b0);

    rst = 1'b0;
    repeat (10) step();
    checkBit("idle_valid", evt_valid, 1'b0);
    checkBit("idle_fault", fault, 1'b0);
    checkBit("idle_overflow", overflow, 1'b0);

    evt_ready = 1'b1;
    doEvent(1'b1, 1'b0, rec(1'b1, 1'b0, 1'b0, 8'd1, 8'd0), "a_single");

    resetDut();
    doEvent(1'b1, 1'b1, rec(1'b1, 1'b1, 1'b0, 8'd1, 8'd1), "ab_1");
    doEvent(1'b1, 1'b1, rec(1'b1, 1'b1, 1'b0, 8'd2, 8'd2), "ab_2");
    doEvent(1'b1, 1'b1, rec(1'b1, 1'b1, 1'b0, 8'd3, 8'd3), "ab_3");

    a_inv1 = a_val;
    step();
    applyStimulus(a_val, b_val);
    step();
    step();
    step();
    checkBit("mm1_fault", fault, 1'b0);
    checkBit("mm1_valid", evt_valid, 1'b0);

    a_inv1 = a_val;
    step();
    step();
    checkBit("mm2_suspect", fault, 1'b0);
    step();
    checkBit("mm2_fault", fault, 1'b1);
    checkBit("mm2_latency", evt_valid, 1'b0);
    step();
    checkBit("mm2_valid", evt_valid, 1'b1);
    checkOutput("mm2_data", evt_data[18:0], rec(1'b0, 1'b0, 1'b1, 8'd3, 8'd3));
    step();
    checkBit("mm2_popped", evt_valid, 1'b0);

    clr = 1'b1;
    step();
    clr = 1'b0;
    checkBit("clr_mm_fault", fault, 1'b1);
    step();
    checkBit("sticky_no_rec", evt_valid, 1'b0);

    applyStimulus(a_val, b_val);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checkBit("clr_ok_fault", fault, 1'b0);
    step();
    step();
    checkBit("clr_ok_valid", evt_valid, 1'b0);

    resetDut();
    evt_ready = 1'b0;
    repeat (6) begin
      applyStimulus(~a_val, b_val);
      step();
    end
    step();
    step();
    checkBit("full_overflow", overflow, 1'b1);
    evt_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checkBit("drain_valid", evt_valid, 1'b1);
      checkOutput("drain_data", evt_data[18:0], rec(1'b1, 1'b0, 1'b0, 8'(i), 8'd0));
      step();
    end
    checkBit("drain_empty", evt_valid, 1'b0);
    checkBit("drain_overflow", overflow, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    checkBit("clr_overflow", overflow, 1'b0);
    doEvent(1'b1, 1'b0, rec(1'b1, 1'b0, 1'b0, 8'd7, 8'd0), "after_drop");

    evt_ready = 1'b0;
    applyStimulus(~a_val, b_val);
    step();
    applyStimulus(~a_val, b_val);
    step();
    step();
    step();
    checkBit("two_valid", evt_valid, 1'b1);
    checkOutput("two_head", evt_data[18:0], rec(1'b1, 1'b0, 1'b0, 8'd8, 8'd0));
    rst = 1'b1;
    #1;
    checkBit("async_rst_valid", evt_valid, 1'b0);
    checkOutput("async_rst_data", evt_data[18:0], 19'h0);
    step();
    rst = 1'b0;
    step();
    step();
    step();
    evt_ready = 1'b1;
    checkBit("post_rst_fault", fault, 1'b0);
    checkBit("post_rst_overflow", overflow, 1'b0);
    doEvent(1'b1, 1'b0, rec(1'b1, 1'b0, 1'b0, 8'd1, 8'd0), "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
